router_pkt_reader: RTL and testbench

- Destination-side consumer for one router output FIFO: drains bytes through the FIFO read port (read_enb/data_out) and re-frames them into packets.
- Parses header {len[7:2], addr[1:0]}, counts payload, checks the trailing parity byte (XOR of header and payload), and streams header and payload to a downstream sink with SOF/EOF markers.
- Reports per-packet status and keeps running packet/error counters.
- Sits between an output FIFO and the destination client. One instance per router port.

---
 rtl/router_pkt_reader.sv | 153 +++++++++++++++
 tb/tb_router_pkt_reader.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_reader.sv
// Destination-side reader for one router output FIFO. It re-frames the byte stream
// into header/payload packets, checks the trailing parity byte and keeps counters.
module router_pkt_reader #(
  parameter logic [1:0] MY_ADDR     = 2'd0,
  parameter int         STALL_LIMIT = 29,
  parameter int         CNT_W       = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             vld_out,
  input  logic [7:0]       data_out,
  input  logic             soft_reset,
  input  logic             sink_ready,
  output logic             read_enb,
  output logic [7:0]       pkt_data,
  output logic             pkt_valid,
  output logic             pkt_sof,
  output logic             pkt_eof,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             addr_err,
  output logic             pkt_abort,
  output logic             stall_alarm,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int            SW        = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

  typedef enum logic [1:0] {S_HDR, S_PAY, S_PAR} state_t;

  state_t        state, state_nxt;
  logic          rd_q;
  logic [7:0]    par, par_nxt;
  logic [5:0]    rem, rem_nxt;
  logic          addr_mis, addr_mis_nxt;
  logic [SW-1:0] stall_cnt;

  logic          fwd_nxt, sof_nxt, eof_nxt;
  logic          done_nxt, perr_nxt, aerr_nxt, abort_nxt;
  logic          err_inc;

  // A read can only be issued while the FIFO holds data and the sink can take it.
  assign read_enb    = vld_out & sink_ready & ~soft_reset;
  assign stall_alarm = (stall_cnt >= STALL_MAX);
  assign err_inc     = abort_nxt | (done_nxt & (perr_nxt | aerr_nxt));

  always_comb begin
    state_nxt    = state;
    par_nxt      = par;
    rem_nxt      = rem;
    addr_mis_nxt = addr_mis;
    fwd_nxt      = 1'b0;
    sof_nxt      = 1'b0;
    eof_nxt      = 1'b0;
    done_nxt     = 1'b0;
    perr_nxt     = 1'b0;
    aerr_nxt     = 1'b0;
    abort_nxt    = 1'b0;
    if (soft_reset) begin
      // The in-flight byte is dropped; only a packet already under way counts as aborted.
      state_nxt    = S_HDR;
      par_nxt      = '0;
      rem_nxt      = '0;
      addr_mis_nxt = 1'b0;
      abort_nxt    = (state != S_HDR);
    end else if (rd_q) begin
      case (state)
        S_HDR: begin
          fwd_nxt      = 1'b1;
          sof_nxt      = 1'b1;
          par_nxt      = data_out;
          rem_nxt      = data_out[7:2];
          addr_mis_nxt = (data_out[1:0] != MY_ADDR);
          if (data_out[7:2] == 6'd0) begin
            eof_nxt   = 1'b1;
            state_nxt = S_PAR;
          end else begin
            state_nxt = S_PAY;
          end
        end
        S_PAY: begin
          fwd_nxt = 1'b1;
          par_nxt = par ^ data_out;
          rem_nxt = rem - 6'd1;
          if (rem == 6'd1) begin
            eof_nxt   = 1'b1;
            state_nxt = S_PAR;
          end
        end
        S_PAR: begin
          done_nxt  = 1'b1;
          perr_nxt  = (data_out != par);
          aerr_nxt  = addr_mis;
          state_nxt = S_HDR;
        end
        default: state_nxt = S_HDR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_HDR;
      rd_q       <= 1'b0;
      par        <= '0;
      rem        <= '0;
      addr_mis   <= 1'b0;
      pkt_data   <= '0;
      pkt_valid  <= 1'b0;
      pkt_sof    <= 1'b0;
      pkt_eof    <= 1'b0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      pkt_abort  <= 1'b0;
      pkt_count  <= '0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      rd_q       <= read_enb;
      par        <= par_nxt;
      rem        <= rem_nxt;
      addr_mis   <= addr_mis_nxt;
      pkt_data   <= fwd_nxt ? data_out : pkt_data;
      pkt_valid  <= fwd_nxt;
      pkt_sof    <= sof_nxt;
      pkt_eof    <= eof_nxt;
      pkt_done   <= done_nxt;
      parity_err <= perr_nxt;
      addr_err   <= aerr_nxt;
      pkt_abort  <= abort_nxt;
      if (done_nxt && (pkt_count != '1))
        pkt_count <= pkt_count + CNT_W'(1);
      if (err_inc && (err_count != '1))
        err_count <= err_count + CNT_W'(1);
    end
  end

  // Counts consecutive cycles where the FIFO has data but nothing is drained.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (vld_out && !read_enb) begin
      if (stall_cnt < STALL_MAX)
        stall_cnt <= stall_cnt + SW'(1);
    end else begin
      stall_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_router_pkt_reader.sv
// Bench for router_pkt_reader: a queue-based FIFO model feeds the reader while a
// packet-level reference model predicts every output cycle by cycle.
module tb_router_pkt_reader;

  localparam logic [1:0] MY_ADDR     = 2'd1;
  localparam int         STALL_LIMIT = 29;
  localparam int         CNT_W       = 4;
  localparam int         CNT_MAX     = (1 << CNT_W) - 1;

  logic             clock;
  logic             resetn;
  logic             vld_out;
  logic [7:0]       data_out;
  logic             soft_reset;
  logic             sink_ready;
  logic             read_enb;
  logic [7:0]       pkt_data;
  logic             pkt_valid;
  logic             pkt_sof;
  logic             pkt_eof;
  logic             pkt_done;
  logic             parity_err;
  logic             addr_err;
  logic             pkt_abort;
  logic             stall_alarm;
  logic [CNT_W-1:0] pkt_count;
  logic [CNT_W-1:0] err_count;

  router_pkt_reader #(
    .MY_ADDR(MY_ADDR), .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .resetn(resetn), .vld_out(vld_out), .data_out(data_out),
    .soft_reset(soft_reset), .sink_ready(sink_ready), .read_enb(read_enb),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_sof(pkt_sof), .pkt_eof(pkt_eof),
    .pkt_done(pkt_done), .parity_err(parity_err), .addr_err(addr_err),
    .pkt_abort(pkt_abort), .stall_alarm(stall_alarm), .pkt_count(pkt_count),
    .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];

  // Reference model: bytes of the packet being assembled plus predicted outputs.
  logic [7:0] m_pkt[$];
  logic       m_rd;
  logic [7:0] m_byte;
  int         m_stall;
  bit         model_live;
  logic       e_read, e_valid, e_sof, e_eof, e_done, e_perr, e_aerr, e_abort;
  logic [7:0] e_data;
  int         e_pkt, e_err;

  int         mon_fwd, mon_sof, mon_eof, mon_done, mon_abort;
  logic       mon_perr, mon_aerr;
  logic [7:0] mon_bytes[$];
  int         cyc;
  logic       rec_read [64];
  logic [7:0] rec_flags [64];
  logic [7:0] rec_data [64];
  logic [CNT_W-1:0] rec_pcnt [64];
  logic [CNT_W-1:0] rec_ecnt [64];

  int pkt_ref;
  int err_ref;

  typedef struct {
    string       name;
    int          n;
    logic [79:0] bytes;
    int          exp_fwd;
    logic        exp_perr;
    logic        exp_aerr;
  } vec_t;
  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_consume(input logic [7:0] b);
    logic [7:0] hdr;
    logic [7:0] x;
    int         n;
    int         len;
    n = m_pkt.size();
    if (n == 0) begin
      e_valid = 1'b1;
      e_sof   = 1'b1;
      e_data  = b;
      e_eof   = (b[7:2] == 6'd0);
      m_pkt.push_back(b);
    end else begin
      hdr = m_pkt[0];
      len = int'(hdr[7:2]);
      if (n <= len) begin
        e_valid = 1'b1;
        e_data  = b;
        e_eof   = (n == len);
        m_pkt.push_back(b);
      end else begin
        x = 8'h00;
        foreach (m_pkt[i]) x ^= m_pkt[i];
        e_done = 1'b1;
        e_perr = (x != b);
        e_aerr = (hdr[1:0] != MY_ADDR);
        if (e_pkt < CNT_MAX) e_pkt++;
        if ((e_perr || e_aerr) && e_err < CNT_MAX) e_err++;
        m_pkt.delete();
      end
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, step the model and FIFO.
  task automatic applyStimulus(input logic rstn, input logic sready, input logic srst,
                               input logic ven);
    resetn     = rstn;
    sink_ready = sready;
    soft_reset = srst;
    vld_out    = ven && (fifo_q.size() != 0);
    e_read     = vld_out && sready && !srst;
    @(negedge clock);
    if (model_live) begin
      checkOutput("read_enb", read_enb, e_read);
      checkOutput("pkt_valid", pkt_valid, e_valid);
      if (e_valid) begin
        checkOutput("pkt_data", pkt_data, e_data);
        checkOutput("pkt_sof", pkt_sof, e_sof);
        checkOutput("pkt_eof", pkt_eof, e_eof);
      end
      checkOutput("pkt_done", pkt_done, e_done);
      if (e_done) begin
        checkOutput("parity_err", parity_err, e_perr);
        checkOutput("addr_err", addr_err, e_aerr);
      end
      checkOutput("pkt_abort", pkt_abort, e_abort);
      checkOutput("stall_alarm", stall_alarm, m_stall >= STALL_LIMIT);
      checkOutput("pkt_count", pkt_count, e_pkt);
      checkOutput("err_count", err_count, e_err);
    end
    if (pkt_valid === 1'b1) begin
      mon_fwd++;
      mon_bytes.push_back(pkt_data);
      if (pkt_sof === 1'b1) mon_sof++;
      if (pkt_eof === 1'b1) mon_eof++;
    end
    if (pkt_done === 1'b1) begin
      mon_done++;
      mon_perr = parity_err;
      mon_aerr = addr_err;
    end
    if (pkt_abort === 1'b1) mon_abort++;
    if (cyc < 64) begin
      rec_read[cyc]  = read_enb;
      rec_flags[cyc] = {pkt_valid, pkt_sof, pkt_eof, pkt_done, parity_err, addr_err,
                        pkt_abort, stall_alarm};
      rec_data[cyc]  = pkt_data;
      rec_pcnt[cyc]  = pkt_count;
      rec_ecnt[cyc]  = err_count;
    end
    cyc++;
    if (!rstn) begin
      {e_valid, e_sof, e_eof, e_done, e_perr, e_aerr, e_abort} = '0;
      e_data  = 8'h00;
      e_pkt   = 0;
      e_err   = 0;
      m_pkt.delete();
      m_rd    = 1'b0;
      m_stall = 0;
      model_live = 1'b1;
    end else begin
      {e_valid, e_sof, e_eof, e_done, e_perr, e_aerr, e_abort} = '0;
      if (srst) begin
        if (m_pkt.size() != 0) begin
          e_abort = 1'b1;
          if (e_err < CNT_MAX) e_err++;
        end
        m_pkt.delete();
      end else if (m_rd) begin
        model_consume(m_byte);
      end
      m_rd    = e_read;
      m_stall = (vld_out && !e_read) ? ((m_stall < STALL_LIMIT) ? m_stall + 1 : m_stall) : 0;
    end
    @(posedge clock);
    #1;
    if (e_read && fifo_q.size() != 0) begin
      data_out = fifo_q.pop_front();
      m_byte   = data_out;
    end
    if (!rstn || srst) fifo_q.delete();
  endtask

  task automatic clear_mon();
    mon_fwd = 0; mon_sof = 0; mon_eof = 0; mon_done = 0; mon_abort = 0;
    mon_perr = 1'b0; mon_aerr = 1'b0;
    mon_bytes.delete();
    cyc = 0;
  endtask

  task automatic push_vec(input logic [79:0] bytes, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(bytes[79-8*i -: 8]);
  endtask

  task automatic push_random_packet();
    logic [5:0] len;
    logic [1:0] addr;
    logic [7:0] b;
    logic [7:0] par;
    len  = 6'($urandom_range(0, 6));
    addr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : MY_ADDR;
    b    = {len, addr};
    par  = b;
    fifo_q.push_back(b);
    for (int i = 0; i < int'(len); i++) begin
      b = 8'($urandom);
      par ^= b;
      fifo_q.push_back(b);
    end
    if ($urandom_range(0, 6) == 0) par ^= 8'(1 << $urandom_range(0, 7));
    fifo_q.push_back(par);
  endtask

  function automatic logic [31:0] mon_byte_at(input int i);
    if (i < mon_bytes.size()) return 32'(mon_bytes[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check_all_zero(input string name, input int idx);
    checkOutput({name, "_flags"}, 32'(rec_flags[idx]), 32'h0);
    checkOutput({name, "_data"}, 32'(rec_data[idx]), 32'h0);
    checkOutput({name, "_pkt_count"}, 32'(rec_pcnt[idx]), 32'h0);
    checkOutput({name, "_err_count"}, 32'(rec_ecnt[idx]), 32'h0);
  endtask

  initial begin
    logic [55:0] bp_exp;
    resetn = 1'b0; vld_out = 1'b0; data_out = 8'h00; soft_reset = 1'b0; sink_ready = 1'b0;
    m_rd = 1'b0; m_byte = 8'h00; m_stall = 0; model_live = 1'b0;
    {e_read, e_valid, e_sof, e_eof, e_done, e_perr, e_aerr, e_abort} = '0;
    e_data = 8'h00; e_pkt = 0; e_err = 0;
    pkt_ref = 0; err_ref = 0;

    vecs[0] = '{"good_len3",      5, {8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD, 40'h0}, 4, 1'b0, 1'b0};
    vecs[1] = '{"bad_parity",     5, {8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDC, 40'h0}, 4, 1'b1, 1'b0};
    vecs[2] = '{"wrong_addr",     5, {8'h0E, 8'hA1, 8'hB2, 8'hC3, 8'hDE, 40'h0}, 4, 1'b0, 1'b1};
    vecs[3] = '{"zero_len",       2, {8'h01, 8'h01, 64'h0}, 1, 1'b0, 1'b0};
    vecs[4] = '{"zero_len_errs",  2, {8'h00, 8'hFF, 64'h0}, 1, 1'b1, 1'b1};
    vecs[5] = '{"good_len2",      4, {8'h09, 8'h55, 8'hAA, 8'hF6, 48'h0}, 3, 1'b0, 1'b0};

    $display("[TB] reset");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    clear_mon();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_all_zero("after_reset", 0);

    $display("[TB] single packet timing");
    push_vec(vecs[0].bytes, 5);
    clear_mon();
    repeat (9) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("timing_read_c%0d", i), rec_read[i], (i <= 4));
      checkOutput($sformatf("timing_valid_c%0d", i), rec_flags[i][7], (i >= 2 && i <= 5));
      checkOutput($sformatf("timing_done_c%0d", i), rec_flags[i][4], (i == 6));
    end
    checkOutput("timing_sof_c2", rec_flags[2][6], 1'b1);
    checkOutput("timing_eof_c5", rec_flags[5][5], 1'b1);
    checkOutput("timing_data_c5", rec_data[5], 8'hC3);
    pkt_ref++;
    checkOutput("timing_pkt_count", rec_pcnt[6], 32'(pkt_ref));

    $display("[TB] vector table");
    foreach (vecs[v]) begin
      clear_mon();
      push_vec(vecs[v].bytes, vecs[v].n);
      repeat (vecs[v].n + 6) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      pkt_ref++;
      if (vecs[v].exp_perr || vecs[v].exp_aerr) err_ref++;
      checkOutput({vecs[v].name, "_fwd"}, mon_fwd, vecs[v].exp_fwd);
      checkOutput({vecs[v].name, "_sof"}, mon_sof, 1);
      checkOutput({vecs[v].name, "_eof"}, mon_eof, 1);
      checkOutput({vecs[v].name, "_done"}, mon_done, 1);
      checkOutput({vecs[v].name, "_hdr"}, mon_byte_at(0), 32'(vecs[v].bytes[79:72]));
      checkOutput({vecs[v].name, "_perr"}, mon_perr, vecs[v].exp_perr);
      checkOutput({vecs[v].name, "_aerr"}, mon_aerr, vecs[v].exp_aerr);
      checkOutput({vecs[v].name, "_pkt_count"}, pkt_count, pkt_ref);
      checkOutput({vecs[v].name, "_err_count"}, err_count, err_ref);
    end

    $display("[TB] backpressure across two packets");
    clear_mon();
    push_vec(vecs[0].bytes, 5);
    push_vec(vecs[5].bytes, 4);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, !(i >= 3 && i <= 5), 1'b0, 1'b1);
    checkOutput("bp_inflight_valid", rec_flags[4][7], 1'b1);
    for (int i = 5; i <= 7; i++)
      checkOutput($sformatf("bp_quiet_c%0d", i), rec_flags[i][7], 1'b0);
    bp_exp = {8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'h09, 8'h55, 8'hAA};
    checkOutput("bp_fwd", mon_fwd, 7);
    for (int i = 0; i < 7; i++)
      checkOutput($sformatf("bp_byte%0d", i), mon_byte_at(i), 32'(bp_exp[55-8*i -: 8]));
    checkOutput("bp_done", mon_done, 2);
    pkt_ref += 2;
    checkOutput("bp_pkt_count", pkt_count, pkt_ref);

    $display("[TB] soft reset mid packet");
    clear_mon();
    push_vec(vecs[0].bytes, 5);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, (i == 4), 1'b1);
    checkOutput("abort_pulse_c5", rec_flags[5][1], 1'b1);
    checkOutput("abort_count", mon_abort, 1);
    checkOutput("abort_no_done", mon_done, 0);
    checkOutput("abort_no_eof", mon_eof, 0);
    checkOutput("abort_fwd", mon_fwd, 3);
    err_ref++;
    checkOutput("abort_err_count", err_count, err_ref);
    clear_mon();
    push_vec(vecs[5].bytes, 4);
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    pkt_ref++;
    checkOutput("post_abort_fwd", mon_fwd, 3);
    checkOutput("post_abort_hdr", mon_byte_at(0), 32'h09);
    checkOutput("post_abort_done", mon_done, 1);
    checkOutput("post_abort_perr", mon_perr, 1'b0);
    checkOutput("post_abort_pkt_count", pkt_count, pkt_ref);

    $display("[TB] stall alarm");
    clear_mon();
    push_vec(vecs[0].bytes, 5);
    for (int i = 0; i < 42; i++) applyStimulus(1'b1, (i >= 40), 1'b0, 1'b1);
    checkOutput("stall_c28", rec_flags[28][0], 1'b0);
    checkOutput("stall_c29", rec_flags[29][0], 1'b1);
    checkOutput("stall_c40", rec_flags[40][0], 1'b1);
    checkOutput("stall_c41", rec_flags[41][0], 1'b0);
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);

    $display("[TB] reset mid packet with soft reset");
    clear_mon();
    push_vec(vecs[0].bytes, 5);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_all_zero("mid_reset", 4);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2500; i++) begin
      if (fifo_q.size() < 4) push_random_packet();
      applyStimulus(1'b1, ($urandom_range(0, 99) < 75), ($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 99) < 92));
    end
    if (e_pkt == CNT_MAX) checkOutput("pkt_count_saturated", pkt_count, CNT_MAX);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
